deadtime_gen: RTL and testbench
===============================

DEADTIME_GEN -- requirements
Module: deadtime_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of the dead-time value and counters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstb  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports pwmA, pwmB, pwmC  input  1 each  raw phase PWM commands from the space-vector modulator.
REQ-005 SHALL have port halt  input  1  modulator period-boundary flag (carrier counter == 0).
REQ-006 SHALL have port dead_time  input  CNT_WIDTH  requested dead time in clk cycles.
REQ-007 SHALL have port fault  input  1  synchronous fault request, level-sensitive, active-high.
REQ-008 SHALL have port fault_clr  input  1  fault acknowledge, sampled per edge.
REQ-009 SHALL have ports hA, lA, hB, lB, hC, lC  output  1 each  high-side and low-side gate drives per phase.
REQ-010 SHALL have port fault_latched  output  1  fault lockout active.
REQ-011 SHALL have port dt_active  output  CNT_WIDTH  dead-time value currently in use.

Function
REQ-012 SHALL run three identical independent per-phase FSMs with states SAFE, LOW_ON, DEAD_H, HIGH_ON, DEAD_L.
REQ-013 SHALL drive outputs directly from flip-flops, no logic between flop and port; h=1 only in HIGH_ON, l=1 only in LOW_ON.
REQ-014 SHALL never assert h and l of the same phase in the same cycle, under any input sequence.
REQ-015 SHALL compute dt_eff = dt_active if nonzero, else 1; dt_active == 0 never yields zero dead time.
REQ-016 SHALL load dt_active from dead_time only on an edge where halt==1 or fault_latched==1; otherwise hold it.
REQ-017 SHALL transition SAFE -> LOW_ON on an edge where fault_latched==0 and fault==0.
REQ-018 SHALL transition LOW_ON -> DEAD_H when pwm==1, loading the phase counter with dt_eff-1.
REQ-019 SHALL, in DEAD_H: pwm==0 -> LOW_ON (aborted edge); else counter==0 -> HIGH_ON; else decrement counter.
REQ-020 SHALL transition HIGH_ON -> DEAD_L when pwm==0, loading the counter with dt_eff-1.
REQ-021 SHALL, in DEAD_L: pwm==1 -> HIGH_ON (aborted edge); else counter==0 -> LOW_ON; else decrement counter.
REQ-022 SHALL make both drives of a phase low for exactly dt_eff cycles between any l-to-h or h-to-l handover.
REQ-023 SHALL register the pwm rise so the first dead cycle begins one cycle after pwm is sampled high; h asserts dt_eff+1 cycles after the pwm edge is sampled.
REQ-024 SHALL use the dt_eff value in force at counter load for the whole dead interval; a dt_active update mid-interval does not alter it.
REQ-025 SHALL, on an edge with fault==1, set fault_latched=1 and force all phases to SAFE; all six drives are 0 from the next cycle.
REQ-026 SHALL give fault priority over fault_clr and over every phase transition on the same edge.
REQ-027 SHALL clear fault_latched only on an edge with fault_clr==1 and fault==0; phases leave SAFE on the following edge per REQ-017.
REQ-028 SHALL hold fault_latched while fault_clr==0, regardless of fault deasserting.
REQ-029 SHALL allow SAFE -> LOW_ON without dead time; both drives are already off in SAFE.

Reset
REQ-030 SHALL, while rstb==0, hold all six drives 0, all phases SAFE, counters 0, fault_latched 0, dt_active all-ones.
REQ-031 SHALL, on reset assertion mid-operation, including mid dead interval, force drives to 0 immediately (asynchronous), with no waiting for a clock.
REQ-032 SHALL enter LOW_ON on the first edge after rstb deasserts if fault==0, so lA=lB=lC=1 one cycle after release.

Verification
REQ-033 Reset release with CNT_WIDTH=8, fault=0, pwm*=0 -> one cycle later lA/lB/lC=1, hA/hB/hC=0, dt_active=255.
REQ-034 dead_time=4 loaded with halt=1, then pwmA rises -> lA drops the next cycle, both drives low 4 cycles, hA=1 afterwards; pwmA falls -> 4 dead cycles, then lA=1.
REQ-035 dead_time=0 loaded -> dt_active=0, dead interval is 1 cycle; a 2-cycle pwmB pulse with dead_time=6 aborts in DEAD_H, so hB never asserts and lB returns.
REQ-036 fault=1 while hC=1 -> all drives 0 next cycle, fault_latched=1; fault_clr with fault=1 -> stays latched; fault=0 plus fault_clr -> latch clears, lA/lB/lC=1 one cycle later.
REQ-037 dead_time changed 10 -> 3 with halt=0 -> dt_active stays 10 until a halt=1 edge; an interval already started finishes at its original length.
REQ-038 Randomised pwm/halt/fault/reset for 1e5 cycles -> h&l never both 1 in any phase; every handover has exactly dt_eff dead cycles.

Source files
------------

// File: rtl/deadtime_gen.sv
// Three-phase complementary gate driver with programmable dead time and fault lockout.
module deadtime_gen #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 pwmA,
  input  logic                 pwmB,
  input  logic                 pwmC,
  input  logic                 halt,
  input  logic [CNT_WIDTH-1:0] dead_time,
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic                 hA,
  output logic                 lA,
  output logic                 hB,
  output logic                 lB,
  output logic                 hC,
  output logic                 lC,
  output logic                 fault_latched,
  output logic [CNT_WIDTH-1:0] dt_active
);

  localparam int unsigned NUM_PHASES = 3;

  typedef enum logic [2:0] {
    ST_SAFE    = 3'd0,
    ST_LOW_ON  = 3'd1,
    ST_DEAD_H  = 3'd2,
    ST_HIGH_ON = 3'd3,
    ST_DEAD_L  = 3'd4
  } phase_state_t;

  logic [NUM_PHASES-1:0] w_pwm_in;
  logic [NUM_PHASES-1:0] r_pwm;
  logic                  r_fault_latched;
  logic [CNT_WIDTH-1:0]  r_dt_active;
  logic [CNT_WIDTH-1:0]  w_dt_eff;
  logic [CNT_WIDTH-1:0]  w_dt_load;
  logic                  w_force_safe;

  assign w_pwm_in     = {pwmC, pwmB, pwmA};
  // A zero request still yields one dead cycle.
  assign w_dt_eff     = (r_dt_active == '0) ? CNT_WIDTH'(1) : r_dt_active;
  assign w_dt_load    = w_dt_eff - CNT_WIDTH'(1);
  assign w_force_safe = fault | r_fault_latched;

  // Register raw PWM commands; the FSMs act on the registered copy.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_pwm <= '0;
    else       r_pwm <= w_pwm_in;
  end

  // Fault latch: fault sets and wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)          r_fault_latched <= 1'b0;
    else if (fault)     r_fault_latched <= 1'b1;
    else if (fault_clr) r_fault_latched <= 1'b0;
  end

  // Dead-time value only changes at a carrier boundary or while locked out.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                         r_dt_active <= '1;
    else if (halt || r_fault_latched) r_dt_active <= dead_time;
  end

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
    phase_state_t         r_state;
    phase_state_t         w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_h;
    logic                 r_l;

    // Per-phase next-state and dead-time counter.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_force_safe) begin
        w_state_nxt = ST_SAFE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          ST_SAFE: w_state_nxt = ST_LOW_ON;
          ST_LOW_ON: begin
            if (r_pwm[p]) begin
              w_state_nxt = ST_DEAD_H;
              w_cnt_nxt   = w_dt_load;
            end
          end
          ST_DEAD_H: begin
            if (!r_pwm[p])          w_state_nxt = ST_LOW_ON;
            else if (r_cnt == '0)   w_state_nxt = ST_HIGH_ON;
            else                    w_cnt_nxt   = r_cnt - CNT_WIDTH'(1);
          end
          ST_HIGH_ON: begin
            if (!r_pwm[p]) begin
              w_state_nxt = ST_DEAD_L;
              w_cnt_nxt   = w_dt_load;
            end
          end
          ST_DEAD_L: begin
            if (r_pwm[p])           w_state_nxt = ST_HIGH_ON;
            else if (r_cnt == '0)   w_state_nxt = ST_LOW_ON;
            else                    w_cnt_nxt   = r_cnt - CNT_WIDTH'(1);
          end
          default: begin
            w_state_nxt = ST_SAFE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    // State, counter and gate drives; drives are decoded from the next state into flops.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_state <= ST_SAFE;
        r_cnt   <= '0;
        r_h     <= 1'b0;
        r_l     <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_h     <= (w_state_nxt == ST_HIGH_ON);
        r_l     <= (w_state_nxt == ST_LOW_ON);
      end
    end
  end

  assign hA            = g_phase[0].r_h;
  assign lA            = g_phase[0].r_l;
  assign hB            = g_phase[1].r_h;
  assign lB            = g_phase[1].r_l;
  assign hC            = g_phase[2].r_h;
  assign lC            = g_phase[2].r_l;
  assign fault_latched = r_fault_latched;
  assign dt_active     = r_dt_active;

endmodule

// File: tb/tb_deadtime_gen.sv
// Directed bench for deadtime_gen: reset, dead-time timing, aborts, dt update, fault lockout.
module tb_deadtime_gen;

  localparam int unsigned CNT_WIDTH = 8;

  logic                 clk;
  logic                 rstb;
  logic                 pwmA, pwmB, pwmC;
  logic                 halt;
  logic [CNT_WIDTH-1:0] dead_time;
  logic                 fault;
  logic                 fault_clr;
  logic                 hA, lA, hB, lB, hC, lC;
  logic                 fault_latched;
  logic [CNT_WIDTH-1:0] dt_active;

  int n_cmp;
  int n_fail;

  deadtime_gen #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .pwmA          (pwmA),
    .pwmB          (pwmB),
    .pwmC          (pwmC),
    .halt          (halt),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .hA            (hA),
    .lA            (lA),
    .hB            (hB),
    .lB            (lB),
    .hC            (hC),
    .lC            (lC),
    .fault_latched (fault_latched),
    .dt_active     (dt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] drv();
    return {hA, lA, hB, lB, hC, lC};
  endfunction

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rstb = 1'b0; pwmA = 1'b0; pwmB = 1'b0; pwmC = 1'b0;
    halt = 1'b0; dead_time = '0; fault = 1'b0; fault_clr = 1'b0;

    // Reset hold values
    step(); step();
    check("rst_drv", 32'(drv()), 32'h00);
    check("rst_flt", 32'(fault_latched), 32'h0);
    check("rst_dt", 32'(dt_active), 32'hFF);

    // Release: all phases LOW_ON after one edge, dt untouched
    rstb = 1'b1;
    step();
    check("rel_drv", 32'(drv()), 32'h15);
    check("rel_dt", 32'(dt_active), 32'hFF);

    // Load dead_time=4 at a halt edge
    halt = 1'b1; dead_time = 8'd4;
    step();
    halt = 1'b0;
    check("dt4", 32'(dt_active), 32'd4);

    // pwmA rise: one registering cycle, 4 dead cycles, then hA
    pwmA = 1'b1;
    step();
    check("a_pre", 32'({hA, lA}), 32'b01);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a_deadH", 32'({hA, lA}), 32'b00);
    end
    step();
    check("a_high", 32'({hA, lA}), 32'b10);

    // pwmA fall: 4 dead cycles, then lA
    pwmA = 1'b0;
    step();
    check("a_hold", 32'({hA, lA}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a_deadL", 32'({hA, lA}), 32'b00);
    end
    step();
    check("a_low", 32'({hA, lA}), 32'b01);

    // dead_time=0 gives a single dead cycle
    halt = 1'b1; dead_time = 8'd0;
    step();
    halt = 1'b0;
    check("dt0", 32'(dt_active), 32'd0);
    pwmA = 1'b1;
    step();
    step();
    check("z_dead", 32'({hA, lA}), 32'b00);
    step();
    check("z_high", 32'({hA, lA}), 32'b10);
    pwmA = 1'b0;
    step();
    step();
    check("z_deadL", 32'({hA, lA}), 32'b00);
    step();
    check("z_low", 32'({hA, lA}), 32'b01);

    // dead_time=6, 2-cycle pwmB pulse aborts in DEAD_H
    halt = 1'b1; dead_time = 8'd6;
    step();
    halt = 1'b0;
    pwmB = 1'b1;
    step();
    step();
    pwmB = 1'b0;
    check("b_dead1", 32'({hB, lB}), 32'b00);
    step();
    check("b_dead2", 32'({hB, lB}), 32'b00);
    step();
    check("b_abort", 32'({hB, lB}), 32'b01);

    // dt 10 -> 3 without halt holds; interval in progress keeps length 10
    halt = 1'b1; dead_time = 8'd10;
    step();
    halt = 1'b0;
    check("dt10", 32'(dt_active), 32'd10);
    dead_time = 8'd3;
    step();
    check("dt_hold", 32'(dt_active), 32'd10);
    pwmC = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 1) halt = 1'b1;
      if (i == 2) halt = 1'b0;
      step();
      check("c_dead", 32'({hC, lC}), 32'b00);
      if (i == 2) check("dt3", 32'(dt_active), 32'd3);
    end
    step();
    check("c_high", 32'({hC, lC}), 32'b10);

    // Fault while hC=1
    fault = 1'b1; pwmC = 1'b0;
    step();
    check("f_drv", 32'(drv()), 32'h00);
    check("f_lat", 32'(fault_latched), 32'h1);
    fault_clr = 1'b1;
    step();
    check("f_prio", 32'(fault_latched), 32'h1);
    fault = 1'b0; fault_clr = 1'b0; dead_time = 8'd5;
    step();
    check("f_hold", 32'(fault_latched), 32'h1);
    check("f_hold_drv", 32'(drv()), 32'h00);
    check("f_dtload", 32'(dt_active), 32'd5);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("f_clr", 32'(fault_latched), 32'h0);
    check("f_clr_drv", 32'(drv()), 32'h00);
    step();
    check("f_resume", 32'(drv()), 32'h15);

    // Random activity: the two drives of a phase are never both on
    for (int i = 0; i < 300; i++) begin
      pwmA = 1'($urandom_range(0, 1));
      pwmB = 1'($urandom_range(0, 1));
      pwmC = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 7) == 0);
      dead_time = 8'($urandom_range(0, 3));
      step();
      check("excl", 32'({hA & lA, hB & lB, hC & lC}), 32'h0);
    end
    pwmA = 1'b0; pwmB = 1'b0; pwmC = 1'b0; halt = 1'b1; dead_time = 8'd5;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Async reset while hA is on
    pwmA = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("ar_high", 32'({hA, lA}), 32'b10);
    #2 rstb = 1'b0;
    #1;
    check("ar_drv", 32'(drv()), 32'h00);
    check("ar_dt", 32'(dt_active), 32'hFF);
    step();
    rstb = 1'b1; pwmA = 1'b0;
    step();
    check("ar_rel", 32'(drv()), 32'h15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
